// File: rtl/clock_div_pkg.sv
// ---------------------------------------------------------------------------
// clock_div_pkg
// Shared definitions for the programmable clock-divider family.
//   state_t       : divider run state (IDLE / RUN)
//   DEFAULT_WIDTH : default width of the divisor field
// ---------------------------------------------------------------------------
package clock_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/clock_div_signal_if.sv
// ---------------------------------------------------------------------------
// clock_div_signal_if
// Configuration handshake for clock_div_signal.
//   cfg_valid : requester has a config to offer
//   cfg_ready : divider can take a config (nothing pending)
//   cfg_div   : requested half-period minus one
//   cfg_en    : requested run (1) / stop (0)
// master = config source, slave = divider.
// ---------------------------------------------------------------------------
interface clock_div_signal_if #(
    parameter int WIDTH = clock_div_pkg::DEFAULT_WIDTH
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_en;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_en,
        output cfg_ready
    );

endinterface

// File: rtl/clock_div_signal.sv
// ---------------------------------------------------------------------------
// clock_div_signal
// Programmable integer divider producing a registered, glitch-free 50%-duty
// signal that drives a signal-to-clock conversion cell. Each half-period
// lasts div+1 input cycles. New settings are staged in a single pending
// slot and only take effect at a period boundary (the falling-edge cycle),
// so the derived clock never sees a runt pulse.
//
// Ports:
//   clock      : input clock, all state on the rising edge
//   reset      : asynchronous active-high reset
//   cfg        : configuration handshake (slave side)
//   signal_out : registered divided signal
//   running    : high while in RUN
//   div_active : divisor currently in effect
// ---------------------------------------------------------------------------
module clock_div_signal
    import clock_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    clock_div_signal_if.slave    cfg,
    output logic                 signal_out,
    output logic                 running,
    output logic [WIDTH-1:0]     div_active
);

    state_t           state_q, state_n;
    logic [WIDTH-1:0] div_q, div_n;
    logic [WIDTH-1:0] cnt_q, cnt_n;
    logic             out_q, out_n;
    logic             pend_v, pend_v_n;
    logic [WIDTH-1:0] pend_div, pend_div_n;
    logic             pend_en, pend_en_n;

    logic             accept;
    logic             terminal;

    // Only one config can be held; the slot reopens the cycle after apply.
    assign cfg.cfg_ready = !pend_v;
    assign accept        = cfg.cfg_valid && !pend_v;
    assign terminal      = (cnt_q == div_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            pend_v   <= 1'b0;
            pend_div <= '0;
            pend_en  <= 1'b0;
        end else begin
            state_q  <= state_n;
            div_q    <= div_n;
            cnt_q    <= cnt_n;
            out_q    <= out_n;
            pend_v   <= pend_v_n;
            pend_div <= pend_div_n;
            pend_en  <= pend_en_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        div_n      = div_q;
        cnt_n      = cnt_q;
        out_n      = out_q;
        pend_v_n   = pend_v;
        pend_div_n = pend_div;
        pend_en_n  = pend_en;

        // Accept needs an empty slot, so it can never collide with an apply
        // below (which needs a full slot).
        if (accept) begin
            pend_div_n = cfg.cfg_div;
            pend_en_n  = cfg.cfg_en;
            pend_v_n   = 1'b1;
        end

        case (state_q)
            IDLE: begin
                out_n = 1'b0;
                cnt_n = '0;
                if (pend_v) begin
                    div_n    = pend_div;
                    pend_v_n = 1'b0;
                    if (pend_en) begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (terminal) begin
                    out_n = !out_q;
                    cnt_n = '0;
                    // Falling-edge cycle is the period boundary: the new
                    // divisor starts with a fresh low phase and cnt is 0,
                    // so cnt can never sit above the new div_q.
                    if (out_q && pend_v) begin
                        div_n    = pend_div;
                        pend_v_n = 1'b0;
                        if (!pend_en) begin
                            state_n = IDLE;
                        end
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign signal_out = out_q;
    assign running    = (state_q == RUN);
    assign div_active = div_q;

endmodule

// File: tb/tb_clock_div_signal.sv
module tb_clock_div_signal;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset;
    logic             signal_out;
    logic             running;
    logic [WIDTH-1:0] div_active;

    clock_div_signal_if #(.WIDTH(WIDTH)) cfg_if ();

    clock_div_signal #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg        (cfg_if),
        .signal_out (signal_out),
        .running    (running),
        .div_active (div_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: a running divider is described as a queue of output
    // levels for the current period (div+1 lows followed by div+1 highs).
    // An empty queue on a RUN cycle marks a period boundary.
    bit m_run;
    bit m_out;
    int m_div;
    bit m_pend;
    int m_pdiv;
    bit m_pen;
    bit m_q[$];

    task automatic model_reset();
        m_run  = 1'b0;
        m_out  = 1'b0;
        m_div  = 0;
        m_pend = 1'b0;
        m_pdiv = 0;
        m_pen  = 1'b0;
        m_q.delete();
    endtask

    task automatic push_period(input int d);
        for (int i = 0; i <= d; i++) m_q.push_back(1'b0);
        for (int i = 0; i <= d; i++) m_q.push_back(1'b1);
    endtask

    task automatic model_edge(input bit v, input int d, input bit e);
        bit acc;
        acc = v && !m_pend;
        if (!m_run) begin
            m_out = 1'b0;
            if (m_pend) begin
                m_div  = m_pdiv;
                m_pend = 1'b0;
                if (m_pen) begin
                    m_run = 1'b1;
                    push_period(m_div);
                    m_out = m_q.pop_front();
                end
            end
        end else begin
            if (m_q.size() == 0) begin
                if (m_pend) begin
                    m_div  = m_pdiv;
                    m_pend = 1'b0;
                    if (!m_pen) m_run = 1'b0;
                end
                if (m_run) push_period(m_div);
            end
            if (m_run) m_out = m_q.pop_front();
            else       m_out = 1'b0;
        end
        if (acc) begin
            m_pend = 1'b1;
            m_pdiv = d % (1 << WIDTH);
            m_pen  = e;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("signal_out", 32'(signal_out), 32'(m_out));
        chk("running", 32'(running), 32'(m_run));
        chk("div_active", 32'(div_active), 32'(m_div));
        chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!m_pend));
    endtask

    // Drive inputs, take one rising edge, advance the model, check #1 later.
    task automatic step(input bit v, input int d, input bit e);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_div   = WIDTH'(d);
        cfg_if.cfg_en    = e;
        @(posedge clock);
        model_edge(v, d, e);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    // Hold cfg_valid until the config is taken (bounded).
    task automatic send(input int d, input bit e);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done && n < 700) begin
            done = !m_pend;
            step(1'b1, d, e);
            n++;
        end
        chk("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_out(input bit lvl, input int budget);
        int n;
        n = 0;
        while (signal_out !== lvl && n < budget) begin
            step(1'b0, 0, 1'b0);
            n++;
        end
        chk("wait_signal_level", 32'(signal_out), 32'(lvl));
    endtask

    initial begin
        reset            = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_en    = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #3;
        chk("reset_signal_out", 32'(signal_out), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_div_active", 32'(div_active), 32'd0);
        chk("reset_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        reset = 1'b0;

        // Divide-by-2 start-up.
        idle(2);
        step(1'b1, 0, 1'b1);
        idle(8);

        // Reconfigure to div=2, then request div=0 during a high phase.
        send(2, 1'b1);
        idle(10);
        wait_out(1'b1, 20);
        send(0, 1'b1);
        idle(12);

        // Stop request during a low phase at div=1.
        send(1, 1'b1);
        idle(10);
        wait_out(1'b0, 20);
        send(0, 1'b0);
        idle(12);

        // Config with cfg_en=0 while idle only moves div_active.
        send(6, 1'b0);
        idle(3);

        // Back-to-back configs with cfg_valid held high.
        send(3, 1'b1);
        send(1, 1'b1);
        idle(20);

        // Maximum divisor: 256 high / 256 low.
        send(255, 1'b1);
        idle(1100);
        send(0, 1'b0);
        idle(30);

        // Asynchronous reset in the middle of a high phase.
        send(4, 1'b1);
        wait_out(1'b1, 40);
        step(1'b0, 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset_signal_out", 32'(signal_out), 32'd0);
        chk("async_reset_running", 32'(running), 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        chk("post_reset_div_active", 32'(div_active), 32'd0);
        chk("post_reset_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit e;
            int d;
            v = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 4) != 0);
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
            step(v, d, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
